proj_hasher: RTL and testbench
==============================

Name: proj_hasher

Overview:
- Pipelined MurmurHash3_x86_32 hasher for one 4-byte key (one packed k-mer word) with a per-request seed.
- Produces the 32-bit MinHash signature consumed by the downstream sorter.
- One clock domain; fixed latency; accepts one request per cycle; no backpressure.

Parameters:
- HASHER_DATA_BITS, default proj_pkg::HASHER_SORTER_SIGNATURE (=32): seed, kmer and signature width. Only 32 is legal; other values are an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request qualifier; seed/kmer sampled when high
- seed  input  HASHER_DATA_BITS  hash seed
- kmer  input  HASHER_DATA_BITS  key word; byte 0 = kmer[7:0] (little-endian key)
- out_valid  output  1  signature valid, exactly 4 cycles after the accepting in_valid
- signature  output  HASHER_DATA_BITS  Murmur3 result

Behaviour:
- Function is MurmurHash3_x86_32 of a 4-byte key. All arithmetic is mod 2^32.
  - k = kmer*0xCC9E2D51; k = rotl(k,15); k = k*0x1B873593
  - h = seed^k; h = rotl(h,13); h = h*5 + 0xE6546B64; h ^= 4
  - fmix: h ^= h>>16; h *= 0x85EBCA6B; h ^= h>>13; h *= 0xC2B2AE35; h ^= h>>16
- Four register stages:
  - S1: k after first multiply and rotl
  - S2: h after the ^4 step
  - S3: h after first fmix multiply
  - S4: final h, which drives signature
- Latency is 4 clk edges from the sampling edge to out_valid/signature. Throughput is 1 per cycle; back-to-back requests are supported.
- A valid bit travels with the data through every stage.
- Pipeline data registers load unconditionally each cycle; only the valid bits are qualified. signature is therefore don't-care while out_valid=0, but verification checks it only when out_valid=1.
- Reset (rst_n low, asynchronous): all valid bits and all data registers, including signature, clear to 0 immediately.
- Assertion during a flight drops every in-flight request; no out_valid is produced for them.
- Release is synchronous to clk. The first request is accepted on the first edge with rst_n high.
- No X propagation: all registers are reset.

Decomposition:
- proj_pkg holds:
  - KMER_LEN, BASE_LEN, HASHER_SORTER_SIGNATURE (=32)
  - the Murmur constants C1=0xCC9E2D51, C2=0x1B873593, N=0xE6546B64, F1=0x85EBCA6B, F2=0xC2B2AE35
  - a rotl32 function
- One natural sub-module: proj_hasher_fmix, carrying stages S3–S4 of the finalizer.

Test Plan:
- kmer=0x00000000, seed=0x00000000 -> signature 0x2362F9DE with out_valid high 4 cycles after the sampling edge.
- kmer=0x87654321, seed=0 -> 0xF55B516B. kmer=0x87654321, seed=0x5082EDEE -> 0x2362F9DE.
- kmer=0xFFFFFFFF, seed=0 -> 0x76293B50. kmer=0x61616161, seed=0x9747B28C -> 0x5A97808A.
- Back-to-back: the five vectors above on consecutive cycles -> five consecutive out_valid cycles, results in order. Follow with 32 random kmers at seed 0xAC718ADD, each checked against a C/SV reference model.
- Gaps: in_valid toggled 1,0,1 -> out_valid pattern 1,0,1 delayed by exactly 4 cycles.
- Reset mid-flight: rst_n pulsed low asynchronously with 3 requests in the pipe -> out_valid and signature read 0 immediately. No stale outputs after release. A new request hashes correctly 4 cycles later.

Source files
------------

// File: rtl/proj_pkg.sv
// Shared definitions for the k-mer projection datapath.
// Holds k-mer geometry, the hasher/sorter signature width, the MurmurHash3_x86_32
// mixing constants and a 32-bit rotate-left helper.
package proj_pkg;

    localparam int unsigned KMER_LEN                = 16;  // bases per k-mer
    localparam int unsigned BASE_LEN                = 2;   // bits per base
    localparam int unsigned HASHER_SORTER_SIGNATURE = KMER_LEN * BASE_LEN;

    // MurmurHash3_x86_32 constants
    localparam logic [31:0] C1 = 32'hCC9E_2D51;
    localparam logic [31:0] C2 = 32'h1B87_3593;
    localparam logic [31:0] N  = 32'hE654_6B64;
    localparam logic [31:0] F1 = 32'h85EB_CA6B;
    localparam logic [31:0] F2 = 32'hC2B2_AE35;

    // Rotate left; r is expected in 1..31.
    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned r);
        return (x << r) | (x >> (32 - r));
    endfunction

endpackage

// File: rtl/proj_hasher_fmix.sv
// Murmur3 finalizer, split over two register stages (S3, S4).
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   in_valid    valid bit of the incoming h
//   h_in        hash state after the body/tail step
//   out_valid   valid bit of h_out
//   h_out       fully mixed hash
module proj_hasher_fmix
    import proj_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] h_in,
    output logic        out_valid,
    output logic [31:0] h_out
);

    logic [31:0] s3_h_d, s3_h_q;
    logic        s3_valid_q;
    logic [31:0] s4_h_d, s4_h_q;
    logic        s4_valid_q;

    always_comb begin
        s3_h_d = h_in ^ (h_in >> 16);
        s3_h_d = s3_h_d * F1;
    end

    always_comb begin
        s4_h_d = s3_h_q ^ (s3_h_q >> 13);
        s4_h_d = s4_h_d * F2;
        s4_h_d = s4_h_d ^ (s4_h_d >> 16);
    end

    // Data loads every cycle; only the valid bits carry request qualification.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_h_q     <= '0;
            s3_valid_q <= 1'b0;
            s4_h_q     <= '0;
            s4_valid_q <= 1'b0;
        end else begin
            s3_h_q     <= s3_h_d;
            s3_valid_q <= in_valid;
            s4_h_q     <= s4_h_d;
            s4_valid_q <= s3_valid_q;
        end
    end

    assign out_valid = s4_valid_q;
    assign h_out     = s4_h_q;

endmodule

// File: rtl/proj_hasher.sv
// Pipelined MurmurHash3_x86_32 of one 4-byte key (a packed k-mer) with a
// per-request seed. Produces the MinHash signature for the downstream sorter.
// Four register stages, fixed latency, one request per cycle, no backpressure.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   in_valid    request qualifier; seed/kmer sampled when high
//   seed        hash seed
//   kmer        key word, byte 0 = kmer[7:0]
//   out_valid   signature valid, 4 cycles after the accepting in_valid
//   signature   hash result (don't-care while out_valid is low)
module proj_hasher
    import proj_pkg::*;
#(
    parameter int unsigned HASHER_DATA_BITS = proj_pkg::HASHER_SORTER_SIGNATURE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [HASHER_DATA_BITS-1:0] seed,
    input  logic [HASHER_DATA_BITS-1:0] kmer,
    output logic                        out_valid,
    output logic [HASHER_DATA_BITS-1:0] signature
);

    // The datapath is the 32-bit Murmur variant only.
    if (HASHER_DATA_BITS != 32) begin : g_bad_width
        $error("proj_hasher: HASHER_DATA_BITS must be 32");
    end

    // S1: k after first multiply and rotate; seed travels alongside.
    logic [31:0] s1_k_d, s1_k_q;
    logic [31:0] s1_seed_q;
    logic        s1_valid_q;

    // S2: h after the length xor.
    logic [31:0] s2_k;
    logic [31:0] s2_h_d, s2_h_q;
    logic        s2_valid_q;

    always_comb begin
        s1_k_d = kmer * C1;
        s1_k_d = rotl32(s1_k_d, 15);
    end

    always_comb begin
        s2_k   = s1_k_q * C2;
        s2_h_d = s1_seed_q ^ s2_k;
        s2_h_d = rotl32(s2_h_d, 13);
        s2_h_d = s2_h_d * 32'd5 + N;
        s2_h_d = s2_h_d ^ 32'd4;  // key length in bytes
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_k_q     <= '0;
            s1_seed_q  <= '0;
            s1_valid_q <= 1'b0;
            s2_h_q     <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_k_q     <= s1_k_d;
            s1_seed_q  <= seed;
            s1_valid_q <= in_valid;
            s2_h_q     <= s2_h_d;
            s2_valid_q <= s1_valid_q;
        end
    end

    // S3-S4: finalizer.
    proj_hasher_fmix u_fmix (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s2_valid_q),
        .h_in      (s2_h_q),
        .out_valid (out_valid),
        .h_out     (signature)
    );

endmodule

// File: tb/tb_proj_hasher.sv
// Self-checking bench for proj_hasher: directed Murmur3 vectors, back-to-back
// and gapped traffic, random keys against a behavioural reference, and an
// asynchronous reset with requests in flight.
module tb_proj_hasher;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] seed;
    logic [31:0] kmer;
    logic        out_valid;
    logic [31:0] signature;

    int n_checks = 0;
    int n_fails  = 0;

    // Expected-output delay line: index 3 is what the DUT should show now.
    logic        m_v [4];
    logic [31:0] m_s [4];

    proj_hasher #(
        .HASHER_DATA_BITS (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .seed      (seed),
        .kmer      (kmer),
        .out_valid (out_valid),
        .signature (signature)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Behavioural MurmurHash3_x86_32 for a 4-byte key.
    function automatic logic [31:0] murmur(input logic [31:0] key, input logic [31:0] sd);
        logic [31:0] k;
        logic [31:0] h;
        k = key * 32'hCC9E2D51;
        k = (k << 15) | (k >> 17);
        k = k * 32'h1B873593;
        h = sd ^ k;
        h = (h << 13) | (h >> 19);
        h = h * 32'd5 + 32'hE6546B64;
        h = h ^ 32'd4;
        h = h ^ (h >> 16);
        h = h * 32'h85EBCA6B;
        h = h ^ (h >> 13);
        h = h * 32'hC2B2AE35;
        h = h ^ (h >> 16);
        return h;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            m_v[i] = 1'b0;
            m_s[i] = '0;
        end
    endtask

    // Called at a negedge: drive one cycle of inputs, clock it, check outputs.
    task automatic cycle(input logic v, input logic [31:0] s, input logic [31:0] k,
                         input logic [31:0] e);
        in_valid = v;
        seed     = s;
        kmer     = k;
        @(posedge clk);
        for (int i = 3; i > 0; i--) begin
            m_v[i] = m_v[i-1];
            m_s[i] = m_s[i-1];
        end
        m_v[0] = v & rst_n;
        m_s[0] = e;
        if (!rst_n) clear_model();
        #1;
        check_val("out_valid", {31'b0, out_valid}, {31'b0, m_v[3]});
        if (m_v[3]) check_val("signature", signature, m_s[3]);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    logic [31:0] vk [5];
    logic [31:0] vs [5];
    logic [31:0] ve [5];
    logic [31:0] rk;

    initial begin
        vk[0] = 32'h00000000; vs[0] = 32'h00000000; ve[0] = 32'h2362F9DE;
        vk[1] = 32'h87654321; vs[1] = 32'h00000000; ve[1] = 32'hF55B516B;
        vk[2] = 32'h87654321; vs[2] = 32'h5082EDEE; ve[2] = 32'h2362F9DE;
        vk[3] = 32'hFFFFFFFF; vs[3] = 32'h00000000; ve[3] = 32'h76293B50;
        vk[4] = 32'h61616161; vs[4] = 32'h9747B28C; ve[4] = 32'h5A97808A;

        clear_model();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        seed     = '0;
        kmer     = '0;
        #2 rst_n = 1'b0;
        #1;
        check_val("reset out_valid", {31'b0, out_valid}, 32'h0);
        check_val("reset signature", signature, 32'h0);
        @(negedge clk);
        @(negedge clk);

        // Release together with the first request: accepted on the first high edge.
        rst_n = 1'b1;
        cycle(1'b1, vs[0], vk[0], ve[0]);
        idle(5);

        // Directed vectors back-to-back.
        for (int i = 0; i < 5; i++) cycle(1'b1, vs[i], vk[i], ve[i]);
        idle(5);

        // Random keys at a fixed seed, back-to-back.
        for (int i = 0; i < 32; i++) begin
            rk = $urandom;
            cycle(1'b1, 32'hAC718ADD, rk, murmur(rk, 32'hAC718ADD));
        end
        idle(5);

        // Gapped traffic.
        cycle(1'b1, vs[3], vk[3], ve[3]);
        cycle(1'b0, vs[1], vk[1], ve[1]);
        cycle(1'b1, vs[4], vk[4], ve[4]);
        idle(5);

        // Asynchronous reset with three requests in flight.
        cycle(1'b1, vs[1], vk[1], ve[1]);
        cycle(1'b1, vs[3], vk[3], ve[3]);
        cycle(1'b1, vs[4], vk[4], ve[4]);
        #2 rst_n = 1'b0;
        #1;
        check_val("midflight out_valid", {31'b0, out_valid}, 32'h0);
        check_val("midflight signature", signature, 32'h0);
        clear_model();
        @(negedge clk);
        cycle(1'b1, vs[1], vk[1], ve[1]);  // ignored while held in reset
        cycle(1'b1, vs[3], vk[3], ve[3]);
        rst_n = 1'b1;
        idle(6);
        cycle(1'b1, vs[2], vk[2], ve[2]);
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
